// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_ctrl
// Description : RISC-V data-memory stage with B/H/W access, load extension,
//               misalignment flagging and configurable wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_ctrl #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_out,
  input  logic [31:0] data_rs2,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        memtoreg,
  input  logic [2:0]  funct3,
  output logic [31:0] data_value,
  output logic        stall,
  output logic        misaligned
);

  localparam int         c_AW       = $clog2(DEPTH_WORDS);
  localparam logic [2:0] c_CNT_INIT = (WAIT_STATES > 1) ? 3'(WAIT_STATES - 2) : 3'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic            w_req, w_f3_bad, w_align_bad, w_illegal, w_go, w_access, w_we;
  logic [c_AW-1:0] w_idx;
  logic [31:0]     w_rd, w_load_ext, w_load_result, w_wdata;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [3:0]      w_be;

  assign w_idx = alu_out[2 +: c_AW];
  assign w_req = mem_read | mem_write;

  // Stores take priority over loads, so a store's funct3 must be B/H/W.
  always_comb begin
    w_f3_bad = 1'b0;
    if (mem_write)
      w_f3_bad = !(funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010);
    else
      w_f3_bad = !(funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010 ||
                   funct3 == 3'b100 || funct3 == 3'b101);
  end

  assign w_align_bad = ((funct3[1:0] == 2'b01) && alu_out[0]) ||
                       ((funct3 == 3'b010) && (alu_out[1:0] != 2'b00));
  assign w_illegal   = w_req & (w_f3_bad | w_align_bad);
  assign misaligned  = ~rst & (state_q == S_IDLE) & w_illegal;
  assign w_go        = ~rst & (state_q == S_IDLE) & w_req & ~w_illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // w_access marks the cycle in which load data is valid and a store commits.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    w_access = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_go) begin
          if (WAIT_STATES == 0) begin
            w_access = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = (WAIT_STATES == 1) ? S_DONE : S_WAIT;
            cnt_d   = c_CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (cnt_q == 3'd0) state_d = S_DONE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      S_DONE: begin
        w_access = 1'b1;
        cnt_d    = 3'd0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign w_rd   = mem_q[w_idx];
  assign w_byte = w_rd[{alu_out[1:0], 3'b000} +: 8];
  assign w_half = alu_out[1] ? w_rd[31:16] : w_rd[15:0];

  always_comb begin
    case (funct3)
      3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_ext = {24'd0, w_byte};
      3'b101:  w_load_ext = {16'd0, w_half};
      default: w_load_ext = w_rd;
    endcase
  end

  assign w_load_result = w_access ? w_load_ext : 32'd0;
  assign data_value    = memtoreg ? w_load_result : alu_out;

  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << alu_out[1:0];
        w_wdata = {4{data_rs2[7:0]}};
      end
      2'b01: begin
        w_be    = alu_out[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{data_rs2[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = data_rs2;
      end
    endcase
  end

  assign w_we = w_access & mem_write;

  // RAM array carries no reset so it maps onto block memory.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int l = 0; l < 4; l++) begin
        if (w_be[l]) mem_q[w_idx][8*l +: 8] <= w_wdata[8*l +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_ctrl
// Description : Directed self-checking bench for data_mem_ctrl (N = 0, 2, 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] alu_out;
  logic [31:0] data_rs2;
  logic        memtoreg;
  logic [2:0]  funct3;
  logic [2:0]  rd_v;
  logic [2:0]  wr_v;
  logic [31:0] dv  [3];
  logic        st  [3];
  logic        mis [3];

  int n_cmp;
  int n_bad;

  data_mem_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .alu_out(alu_out), .data_rs2(data_rs2),
    .mem_read(rd_v[0]), .mem_write(wr_v[0]), .memtoreg(memtoreg), .funct3(funct3),
    .data_value(dv[0]), .stall(st[0]), .misaligned(mis[0]));

  data_mem_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) u_dut2 (
    .clk(clk), .rst(rst), .alu_out(alu_out), .data_rs2(data_rs2),
    .mem_read(rd_v[1]), .mem_write(wr_v[1]), .memtoreg(memtoreg), .funct3(funct3),
    .data_value(dv[1]), .stall(st[1]), .misaligned(mis[1]));

  data_mem_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst(rst), .alu_out(alu_out), .data_rs2(data_rs2),
    .mem_read(rd_v[2]), .mem_write(wr_v[2]), .memtoreg(memtoreg), .funct3(funct3),
    .data_value(dv[2]), .stall(st[2]), .misaligned(mis[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One request on instance d, held until stall drops; returns stall count,
  // first-cycle data_value, final data_value and misaligned flag.
  task automatic access(input int d, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic m2r,
                        output int ns, output logic [31:0] first_dv,
                        output logic [31:0] dv_o, output logic mis_o);
    @(negedge clk);
    alu_out  = a;
    data_rs2 = wd;
    funct3   = f3;
    memtoreg = m2r;
    rd_v     = '0;
    wr_v     = '0;
    rd_v[d]  = rd;
    wr_v[d]  = wr;
    #1;
    first_dv = dv[d];
    ns = 0;
    while (st[d] && ns < 16) begin
      ns++;
      @(negedge clk);
      #1;
    end
    if (ns >= 16) chk_val("stall_timeout", 32'(ns), 32'd0);
    dv_o  = dv[d];
    mis_o = mis[d];
    @(negedge clk);
    rd_v = '0;
    wr_v = '0;
  endtask

  int          ns;
  logic [31:0] fdv, rv;
  logic        mf;

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst      = 1'b1;
    alu_out  = 32'h1357_9BDF;
    data_rs2 = 32'd0;
    memtoreg = 1'b0;
    funct3   = 3'b010;
    rd_v     = '0;
    wr_v     = 3'b010;
    #12;
    chk_val("rst_stall", 32'(st[1]), 32'd0);
    chk_val("rst_mis", 32'(mis[1]), 32'd0);
    chk_val("rst_dv_alu", dv[1], 32'h1357_9BDF);
    memtoreg = 1'b1;
    #1;
    chk_val("rst_dv_m2r", dv[1], 32'd0);
    @(negedge clk);
    wr_v = '0;
    rst  = 1'b0;

    // N=0: single cycle, load visible combinationally
    access(0, 1'b0, 1'b1, 3'b010, 32'h0, 32'h0000_1234, 1'b0, ns, fdv, rv, mf);
    chk_val("n0_sw_stall", 32'(ns), 32'd0);
    access(0, 1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1, ns, fdv, rv, mf);
    chk_val("n0_lw_stall", 32'(ns), 32'd0);
    chk_val("n0_lw_data", fdv, 32'h0000_1234);

    // N=2: byte store and sign/zero extended loads
    access(1, 1'b0, 1'b1, 3'b010, 32'h4, 32'h0, 1'b0, ns, fdv, rv, mf);
    access(1, 1'b0, 1'b1, 3'b000, 32'h5, 32'h0000_0080, 1'b0, ns, fdv, rv, mf);
    chk_val("n2_sb_stall", 32'(ns), 32'd2);
    access(1, 1'b1, 1'b0, 3'b000, 32'h5, 32'h0, 1'b1, ns, fdv, rv, mf);
    chk_val("n2_lb_idle_zero", fdv, 32'd0);
    chk_val("n2_lb", rv, 32'hFFFF_FF80);
    chk_val("n2_lb_stall", 32'(ns), 32'd2);
    access(1, 1'b1, 1'b0, 3'b100, 32'h5, 32'h0, 1'b1, ns, fdv, rv, mf);
    chk_val("n2_lbu", rv, 32'h0000_0080);
    access(1, 1'b1, 1'b0, 3'b010, 32'h4, 32'h0, 1'b1, ns, fdv, rv, mf);
    chk_val("n2_lw4", rv, 32'h0000_8000);

    // halfword store to upper half
    access(1, 1'b0, 1'b1, 3'b010, 32'h0, 32'h0, 1'b0, ns, fdv, rv, mf);
    access(1, 1'b0, 1'b1, 3'b001, 32'h2, 32'h1234_BEEF, 1'b0, ns, fdv, rv, mf);
    access(1, 1'b1, 1'b0, 3'b001, 32'h2, 32'h0, 1'b1, ns, fdv, rv, mf);
    chk_val("n2_lh", rv, 32'hFFFF_BEEF);
    access(1, 1'b1, 1'b0, 3'b101, 32'h2, 32'h0, 1'b1, ns, fdv, rv, mf);
    chk_val("n2_lhu", rv, 32'h0000_BEEF);
    access(1, 1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1, ns, fdv, rv, mf);
    chk_val("n2_lw0", rv, 32'hBEEF_0000);

    // illegal requests
    access(1, 1'b1, 1'b0, 3'b010, 32'h5678_9ABE, 32'h0, 1'b0, ns, fdv, rv, mf);
    chk_val("mis_lw_flag", 32'(mf), 32'd1);
    chk_val("mis_lw_stall", 32'(ns), 32'd0);
    chk_val("mis_lw_dv", rv, 32'h5678_9ABE);
    access(1, 1'b0, 1'b1, 3'b010, 32'h1, 32'h1111_2222, 1'b0, ns, fdv, rv, mf);
    chk_val("mis_sw_flag", 32'(mf), 32'd1);
    access(1, 1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1, ns, fdv, rv, mf);
    chk_val("mis_sw_nowrite", rv, 32'hBEEF_0000);
    access(1, 1'b1, 1'b0, 3'b011, 32'h0, 32'h0, 1'b0, ns, fdv, rv, mf);
    chk_val("bad_f3_flag", 32'(mf), 32'd1);
    access(1, 1'b0, 1'b1, 3'b100, 32'h0, 32'h0, 1'b0, ns, fdv, rv, mf);
    chk_val("sbu_flag", 32'(mf), 32'd1);
    access(1, 1'b1, 1'b0, 3'b001, 32'h3, 32'h0, 1'b1, ns, fdv, rv, mf);
    chk_val("mis_lh_flag", 32'(mf), 32'd1);
    chk_val("mis_lh_dv", rv, 32'd0);
    access(1, 1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1, ns, fdv, rv, mf);
    chk_val("bad_nowrite", rv, 32'hBEEF_0000);

    // address wrap and store priority
    access(1, 1'b0, 1'b1, 3'b010, 32'h1000, 32'hCAFE_F00D, 1'b0, ns, fdv, rv, mf);
    access(1, 1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1, ns, fdv, rv, mf);
    chk_val("wrap_lw", rv, 32'hCAFE_F00D);
    access(1, 1'b1, 1'b1, 3'b010, 32'h10, 32'h0BAD_F00D, 1'b0, ns, fdv, rv, mf);
    access(1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b1, ns, fdv, rv, mf);
    chk_val("rdwr_store", rv, 32'h0BAD_F00D);

    // N=3: reset mid-wait drops the pending store
    access(2, 1'b0, 1'b1, 3'b010, 32'h8, 32'h1111_1111, 1'b0, ns, fdv, rv, mf);
    chk_val("n3_sw_stall", 32'(ns), 32'd3);
    @(negedge clk);
    alu_out  = 32'h8;
    data_rs2 = 32'hDEAD_BEEF;
    funct3   = 3'b010;
    memtoreg = 1'b0;
    wr_v[2]  = 1'b1;
    #1;
    chk_val("n3_idle_stall", 32'(st[2]), 32'd1);
    @(negedge clk);
    #1;
    chk_val("n3_wait_stall", 32'(st[2]), 32'd1);
    rst = 1'b1;
    #1;
    chk_val("n3_rst_stall", 32'(st[2]), 32'd0);
    chk_val("n3_rst_mis", 32'(mis[2]), 32'd0);
    chk_val("n3_rst_dv_alu", dv[2], 32'h8);
    memtoreg = 1'b1;
    #1;
    chk_val("n3_rst_dv_m2r", dv[2], 32'd0);
    @(negedge clk);
    wr_v = '0;
    rst  = 1'b0;
    access(2, 1'b1, 1'b0, 3'b010, 32'h8, 32'h0, 1'b1, ns, fdv, rv, mf);
    chk_val("n3_old_value", rv, 32'h1111_1111);
    chk_val("n3_lw_stall", 32'(ns), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
